// File: rtl/seq_training_engine.sv
// Sequential weight-update engine: per epoch one squared error, then NUMBER_WEIGHTS SGD/Manhattan updates.
// Optional: define ADAPTIVE_STEP_EN to build per-weight adaptive Manhattan step registers.
module seq_training_engine #(
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned EXTRA_BIT      = 2,
  parameter int unsigned FRAC_BITS      = 24,
  parameter int unsigned NUMBER_WEIGHTS = 2,
  parameter int unsigned ETA_SHIFT      = 10,
  parameter int unsigned STEP_INIT      = 1024,
  parameter int unsigned ERR_THRESHOLD  = 4096,
  parameter int unsigned MAX_EPOCHS     = 1000,
  localparam int unsigned D  = BIT_WIDTH + EXTRA_BIT,
  localparam int unsigned IW = (NUMBER_WEIGHTS > 1) ? $clog2(NUMBER_WEIGHTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        training_mode,
  input  logic                        error_valid,
  output logic                        error_ready,
  input  logic [D-1:0]                SQUARED_ERROR,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [D-1:0]                DELTA_WEIGHT,
  input  logic [D-1:0]                OLD_WEIGHT,
  output logic [D-1:0]                MEMORY_UPDATED_WEIGHT,
  output logic                        out_valid,
  output logic [IW-1:0]               out_index,
  output logic [D*NUMBER_WEIGHTS-1:0] Best_weights,
  output logic [D-1:0]                Best_error,
  output logic                        training_done
);

  localparam int unsigned EW = $clog2(MAX_EPOCHS + 1);

  if (FRAC_BITS >= D) begin : g_bad_frac
    $error("FRAC_BITS must be below the datapath width");
  end

  typedef enum logic [1:0] {WAIT_ERR, UPDATE, DONE} state_t;
  typedef enum logic [1:0] {SIGN_ZERO = 2'b00, SIGN_POS = 2'b01, SIGN_NEG = 2'b10} sign_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [EW-1:0] epoch_count;
  logic          capture;
  logic          mode;

  logic          err_acc, w_acc, last_w, err_stop;
  sign_t         cur_sign;
  logic [D-1:0]  step_eff;
  logic signed [D:0] old_x, delta_x, sgd_sub, step_x, res_x;
  logic [D-1:0]  new_w;

  assign err_acc  = (state == WAIT_ERR) && error_valid;
  assign w_acc    = (state == UPDATE) && w_valid;
  assign last_w   = (idx == IW'(NUMBER_WEIGHTS - 1));
  assign err_stop = (SQUARED_ERROR <= D'(ERR_THRESHOLD)) ||
                    (epoch_count == EW'(MAX_EPOCHS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_ERR;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_ERR: if (error_valid)       state_nxt = err_stop ? DONE : UPDATE;
      UPDATE:   if (w_valid && last_w) state_nxt = WAIT_ERR;
      DONE:     state_nxt = DONE;
      default:  state_nxt = WAIT_ERR;
    endcase
  end

  // Handshake decodes
  always_comb begin
    error_ready = 1'b0;
    w_ready     = 1'b0;
    case (state)
      WAIT_ERR: error_ready = 1'b1;
      UPDATE:   w_ready     = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    cur_sign = SIGN_ZERO;
    if (DELTA_WEIGHT[D-1])       cur_sign = SIGN_NEG;
    else if (DELTA_WEIGHT != '0) cur_sign = SIGN_POS;
  end

`ifdef ADAPTIVE_STEP_EN
  logic [D-1:0] step_q    [NUMBER_WEIGHTS];
  sign_t        prev_sign [NUMBER_WEIGHTS];
  logic         flip;
  logic [D-1:0] step_half;

  // A sign reversal means the last step overshot: halve it (floor of 1) and use it now
  always_comb begin
    flip      = ((cur_sign == SIGN_POS) && (prev_sign[idx] == SIGN_NEG)) ||
                ((cur_sign == SIGN_NEG) && (prev_sign[idx] == SIGN_POS));
    step_half = step_q[idx] >> 1;
    step_eff  = step_q[idx];
    if (flip) step_eff = (step_half == '0) ? D'(1) : step_half;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUMBER_WEIGHTS; i++) begin
        step_q[i]    <= D'(STEP_INIT);
        prev_sign[i] <= SIGN_ZERO;
      end
    end else if (w_acc && mode) begin
      step_q[idx]    <= step_eff;
      prev_sign[idx] <= cur_sign;
    end
  end
`else
  assign step_eff = D'(STEP_INIT);
`endif

  // Update arithmetic at D+1 bits, saturated back to D
  always_comb begin
    old_x   = {OLD_WEIGHT[D-1], OLD_WEIGHT};
    delta_x = {DELTA_WEIGHT[D-1], DELTA_WEIGHT};
    sgd_sub = delta_x >>> ETA_SHIFT;
    step_x  = {1'b0, step_eff};
    if (!mode)                       res_x = old_x - sgd_sub;
    else if (cur_sign == SIGN_ZERO)  res_x = old_x;
    else if (cur_sign == SIGN_NEG)   res_x = old_x + step_x;
    else                             res_x = old_x - step_x;
    if (res_x[D] != res_x[D-1]) new_w = res_x[D] ? {1'b1, {(D-1){1'b0}}} : {1'b0, {(D-1){1'b1}}};
    else                        new_w = res_x[D-1:0];
  end

  // Epoch bookkeeping, best tracking and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx                   <= '0;
      epoch_count           <= '0;
      capture               <= 1'b0;
      mode                  <= 1'b0;
      Best_error            <= '1;
      Best_weights          <= '0;
      MEMORY_UPDATED_WEIGHT <= '0;
      out_valid             <= 1'b0;
      out_index             <= '0;
      training_done         <= 1'b0;
    end else begin
      out_valid <= w_acc;
      if (err_acc) begin
        mode <= training_mode;
        idx  <= '0;
        if (SQUARED_ERROR < Best_error) begin
          Best_error <= SQUARED_ERROR;
          capture    <= 1'b1;
        end
        if (err_stop) training_done <= 1'b1;
      end
      if (w_acc) begin
        MEMORY_UPDATED_WEIGHT <= new_w;
        out_index             <= idx;
        // The error just accepted was produced by these old weights
        if (capture) Best_weights[D*idx +: D] <= OLD_WEIGHT;
        if (last_w) begin
          idx         <= '0;
          epoch_count <= epoch_count + EW'(1);
          capture     <= 1'b0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_training_engine.sv
// Bench for seq_training_engine: table of epochs, scoreboarded update outputs, hand-written corner sequences.
module tb_seq_training_engine;
  localparam int unsigned D  = 34;
  localparam int unsigned NW = 2;
  localparam int unsigned CW = D * NW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          training_mode = 1'b0, error_valid = 1'b0, w_valid = 1'b0;
  logic [D-1:0]  SQUARED_ERROR = '0, DELTA_WEIGHT = '0, OLD_WEIGHT = '0;
  logic          error_ready, w_ready, out_valid, training_done;
  logic [D-1:0]  MEMORY_UPDATED_WEIGHT, Best_error;
  logic [0:0]    out_index;
  logic [CW-1:0] Best_weights;

  seq_training_engine u_dut (
    .clk(clk), .rst(rst), .training_mode(training_mode),
    .error_valid(error_valid), .error_ready(error_ready), .SQUARED_ERROR(SQUARED_ERROR),
    .w_valid(w_valid), .w_ready(w_ready), .DELTA_WEIGHT(DELTA_WEIGHT), .OLD_WEIGHT(OLD_WEIGHT),
    .MEMORY_UPDATED_WEIGHT(MEMORY_UPDATED_WEIGHT), .out_valid(out_valid), .out_index(out_index),
    .Best_weights(Best_weights), .Best_error(Best_error), .training_done(training_done)
  );

  // Short-run instance for the epoch limit
  logic         l_mode = 1'b0, l_ev = 1'b0, l_wv = 1'b0;
  logic [D-1:0] l_err = '0, l_dlt = '0, l_old = '0;
  logic         l_error_ready, l_w_ready, l_out_valid, l_done;
  logic [D-1:0] l_out, l_best_err, l_bw;
  logic [0:0]   l_out_index;

  seq_training_engine #(.NUMBER_WEIGHTS(1), .MAX_EPOCHS(3)) u_lim (
    .clk(clk), .rst(rst), .training_mode(l_mode),
    .error_valid(l_ev), .error_ready(l_error_ready), .SQUARED_ERROR(l_err),
    .w_valid(l_wv), .w_ready(l_w_ready), .DELTA_WEIGHT(l_dlt), .OLD_WEIGHT(l_old),
    .MEMORY_UPDATED_WEIGHT(l_out), .out_valid(l_out_valid), .out_index(l_out_index),
    .Best_weights(l_bw), .Best_error(l_best_err), .training_done(l_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [D-1:0] w; logic idx;} exp_t;
  exp_t sb[$];

  // Scoreboard: every out_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got 0x%0h idx %0d expected no output", MEMORY_UPDATED_WEIGHT, out_index);
      end else begin
        e = sb.pop_front();
        check("upd_weight", CW'({MEMORY_UPDATED_WEIGHT, out_index}), CW'({e.w, e.idx}));
      end
    end
  end

  task automatic send_err(input logic [D-1:0] e, input logic m);
    check("error_ready", CW'(error_ready), CW'(1));
    error_valid = 1'b1; SQUARED_ERROR = e; training_mode = m;
    @(negedge clk);
    error_valid = 1'b0;
  endtask

  task automatic send_w(input logic i, input logic [D-1:0] o, input logic [D-1:0] d, input logic [D-1:0] x);
    check("w_ready", CW'(w_ready), CW'(1));
    w_valid = 1'b1; OLD_WEIGHT = o; DELTA_WEIGHT = d;
    sb.push_back('{w: x, idx: i});
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  typedef struct {
    logic [D-1:0] err; logic mode;
    logic [D-1:0] o0, d0, x0, o1, d1, x1;
    logic [D-1:0] best_err, bw0, bw1;
  } vec_t;
  vec_t vt[4];

  logic [D-1:0] back_step;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{err: 34'h100000, mode: 1'b0,
              o0: 34'h001000000, d0: 34'h000400000, x0: 34'h000FFF000,
              o1: 34'h1FFFFFFFF, d1: 34'h3FFFFF000, x1: 34'h1FFFFFFFF,
              best_err: 34'h100000, bw0: 34'h001000000, bw1: 34'h1FFFFFFFF};
    vt[1] = '{err: 34'h200000, mode: 1'b0,
              o0: 34'h200000000, d0: 34'h000000400, x0: 34'h200000000,
              o1: 34'h000000000, d1: 34'h3FFFFFC00, x1: 34'h000000001,
              best_err: 34'h100000, bw0: 34'h001000000, bw1: 34'h1FFFFFFFF};
    vt[2] = '{err: 34'h080000, mode: 1'b1,
              o0: 34'h001000000, d0: 34'h000000001, x0: 34'h000FFFC00,
              o1: 34'h200000000, d1: 34'h000000001, x1: 34'h200000000,
              best_err: 34'h080000, bw0: 34'h001000000, bw1: 34'h200000000};
    vt[3] = '{err: 34'h090000, mode: 1'b1,
              o0: 34'h000FFFC00, d0: 34'h000000000, x0: 34'h000FFFC00,
              o1: 34'h000000100, d1: 34'h000000005, x1: 34'h3FFFFFD00,
              best_err: 34'h080000, bw0: 34'h001000000, bw1: 34'h200000000};
`ifdef ADAPTIVE_STEP_EN
    back_step = 34'h200;
`else
    back_step = 34'h400;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_error_ready", CW'(error_ready), CW'(1));
    check("rst_w_ready", CW'(w_ready), CW'(0));
    check("rst_out", CW'({out_valid, out_index, MEMORY_UPDATED_WEIGHT}), CW'(0));
    check("rst_done", CW'(training_done), CW'(0));
    check("rst_best_err", CW'(Best_error), CW'({D{1'b1}}));
    check("rst_best_w", Best_weights, CW'(0));

    // Table-driven epochs: SGD, saturation, Manhattan
    for (int i = 0; i < 4; i++) begin
      send_err(vt[i].err, vt[i].mode);
      send_w(1'b0, vt[i].o0, vt[i].d0, vt[i].x0);
      send_w(1'b1, vt[i].o1, vt[i].d1, vt[i].x1);
      check("epoch_best_err", CW'(Best_error), CW'(vt[i].best_err));
      check("epoch_best_w", Best_weights, {vt[i].bw1, vt[i].bw0});
    end

    // Manhattan step adaptation with best-error tracking (tie does not capture)
    send_err(34'h9000, 1'b1);
    send_w(1'b0, 34'h001000000, 34'h000000001, 34'h000FFFC00);
    send_w(1'b1, 34'h000000005, 34'h000000000, 34'h000000005);
    send_err(34'hA000, 1'b1);
    send_w(1'b0, 34'h001000000, 34'h3FFFFFFFF, 34'h001000000 + back_step);
    send_w(1'b1, 34'h000000007, 34'h000000000, 34'h000000007);
    send_err(34'h9000, 1'b1);
    send_w(1'b0, 34'h001000000, 34'h3FFFFFFFF, 34'h001000000 + back_step);
    send_w(1'b1, 34'h000000009, 34'h000000000, 34'h000000009);
    check("track_best_err", CW'(Best_error), CW'(34'h9000));
    check("track_best_w", Best_weights, {34'h000000005, 34'h001000000});

    // Convergence at threshold; later inputs ignored
    send_err(34'h1000, 1'b0);
    check("conv_done", CW'(training_done), CW'(1));
    check("conv_ready", CW'({error_ready, w_ready}), CW'(0));
    check("conv_best_err", CW'(Best_error), CW'(34'h1000));
    error_valid = 1'b1; SQUARED_ERROR = 34'h10; w_valid = 1'b1;
    OLD_WEIGHT = 34'h123; DELTA_WEIGHT = 34'h400;
    repeat (3) @(negedge clk);
    error_valid = 1'b0; w_valid = 1'b0;
    check("conv_hold_err", CW'(Best_error), CW'(34'h1000));
    check("conv_hold_w", Best_weights, {34'h000000005, 34'h001000000});
    check("conv_hold_done", CW'(training_done), CW'(1));

    // Reset mid-UPDATE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_err(34'h50000, 1'b1);
    send_w(1'b0, 34'h001000000, 34'h000000001, 34'h000FFFC00);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", CW'({out_valid, out_index, MEMORY_UPDATED_WEIGHT}), CW'(0));
    check("mid_rst_best", CW'({training_done, Best_error}), CW'({1'b0, {D{1'b1}}}));
    check("mid_rst_best_w", Best_weights, CW'(0));
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", CW'({error_ready, w_ready}), CW'(2'b10));
    send_err(34'h50000, 1'b1);
    send_w(1'b0, 34'h001000000, 34'h3FFFFFFFF, 34'h001000400);
    send_w(1'b1, 34'h000000000, 34'h000000000, 34'h000000000);

    // Epoch limit on the short-run instance
    for (int e = 0; e < 2; e++) begin
      check("lim_error_ready", CW'(l_error_ready), CW'(1));
      l_ev = 1'b1; l_err = D'(34'h20000 + e * 34'h10000);
      @(negedge clk);
      l_ev = 1'b0;
      check("lim_w_ready", CW'({l_w_ready, l_done}), CW'(2'b10));
      l_wv = 1'b1; l_old = D'(34'h1000 * (e + 1)); l_dlt = '0;
      @(negedge clk);
      l_wv = 1'b0;
      check("lim_out", CW'({l_out_valid, l_out_index, l_out}), CW'({1'b1, 1'b0, D'(34'h1000 * (e + 1))}));
    end
    l_ev = 1'b1; l_err = 34'h30000;
    @(negedge clk);
    l_ev = 1'b0;
    check("lim_done", CW'({l_done, l_w_ready, l_error_ready, l_out_valid}), CW'(4'b1000));
    check("lim_best", CW'({l_best_err, l_bw}), CW'({34'h20000, 34'h1000}));

    repeat (2) @(negedge clk);
    check("sb_drained", CW'(sb.size()), CW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
